lfsr_crypt_engine: RTL and testbench

Parametrised LFSR stream-cipher engine with two modes: encrypt and decrypt.
- Encrypt: reads the config block (preamble length, taps, start) from data memory, writes a padded preamble, then writes the XOR-encrypted message.
- Decrypt: checks the preamble against the keystream, strips it, and writes the plaintext.
- Sits beside dat_mem as its single master: one read port (combinational read data) and one write port (write on clock edge).
- Has a start/busy/done handshake in place of a free-running program counter.

---
 rtl/lfsr_crypt_engine_pkg.sv | 22 ++
 rtl/lfsr_crypt_engine_if.sv | 14 +
 rtl/lfsr_crypt_engine_lfsr.sv | 28 ++
 rtl/lfsr_crypt_engine.sv | 183 ++++++++++++++++++
 tb/tb_lfsr_crypt_engine.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_crypt_engine_pkg.sv
// Shared types and constants for the LFSR stream-cipher engine.
package lfsr_crypt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG_PRE,
    ST_CFG_TAPS,
    ST_CFG_START,
    ST_LOAD,
    ST_PREAMBLE,
    ST_BODY,
    ST_DONE
  } state_e;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam int OFF_PRE   = 0;
  localparam int OFF_TAPS  = 1;
  localparam int OFF_START = 2;

endpackage

// File: rtl/lfsr_crypt_engine_if.sv
// Memory-side bus of the engine: one combinational read port, one clocked write port.
interface lfsr_crypt_engine_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W-1:0] waddr;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;

  modport master (output raddr, output waddr, output wr_en, output wr_data, input rd_data);
  modport slave  (input raddr, input waddr, input wr_en, input wr_data, output rd_data);
endinterface

// File: rtl/lfsr_crypt_engine_lfsr.sv
// Fibonacci LFSR with synchronous seed load and per-cycle advance enable.
module lfsr_n #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] taps_i,
  input  logic [W-1:0] seed_i,
  output logic [W-1:0] state_o
);

  logic [W-1:0] state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else if (load_i) begin
      state_q <= seed_i;
    end else if (en_i) begin
      state_q <= {state_q[W-2:0], ^(state_q & taps_i)};
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/lfsr_crypt_engine.sv
// LFSR stream-cipher engine: reads its config block, then encrypts (with preamble) or decrypts.
module lfsr_crypt_engine
  import lfsr_crypt_pkg::*;
#(
  parameter int              LFSR_W   = 6,
  parameter int              DATA_W   = 8,
  parameter int              ADDR_W   = 8,
  parameter int              MSG_LEN  = 64,
  parameter int              CFG_BASE = 61,
  parameter int              SRC_BASE = 0,
  parameter int              DST_BASE = 64,
  parameter logic [DATA_W-1:0] PAD    = DATA_W'('h5F)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              mode_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] pre_err_cnt_o,
  output logic              cfg_err_o,
  lfsr_crypt_engine_if.master mem
);

  localparam int IDX_W = $clog2(MSG_LEN + 1);
  localparam logic [ADDR_W-1:0] A_PRE   = ADDR_W'(CFG_BASE + OFF_PRE);
  localparam logic [ADDR_W-1:0] A_TAPS  = ADDR_W'(CFG_BASE + OFF_TAPS);
  localparam logic [ADDR_W-1:0] A_START = ADDR_W'(CFG_BASE + OFF_START);

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    plen_q, plen_d;
  logic [LFSR_W-1:0]   taps_q, taps_d;
  logic [LFSR_W-1:0]   seed_q, seed_d;
  logic                cfg_err_q, cfg_err_d;
  logic [ADDR_W-1:0]   pre_err_q, pre_err_d;

  logic                lfsr_load, lfsr_en;
  logic [LFSR_W-1:0]   lfsr_seed, lfsr_state;
  logic [DATA_W-1:0]   ks;
  logic [ADDR_W-1:0]   idx_a, plen_a;
  logic [ADDR_W-1:0]   src_i, src_rel, dst_i, dst_rel;
  logic                last_pre, last_msg, full_pre;

  lfsr_n #(.W(LFSR_W)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (lfsr_load),
    .en_i    (lfsr_en),
    .taps_i  (taps_q),
    .seed_i  (lfsr_seed),
    .state_o (lfsr_state)
  );

  assign ks       = DATA_W'(lfsr_state);
  assign idx_a    = ADDR_W'(idx_q);
  assign plen_a   = ADDR_W'(plen_q);
  // The "rel" addresses index the body relative to the end of the preamble.
  assign src_i    = ADDR_W'(SRC_BASE) + idx_a;
  assign src_rel  = ADDR_W'(SRC_BASE) + idx_a - plen_a;
  assign dst_i    = ADDR_W'(DST_BASE) + idx_a;
  assign dst_rel  = ADDR_W'(DST_BASE) + idx_a - plen_a;
  assign last_pre = (idx_q == plen_q - IDX_W'(1));
  assign last_msg = (idx_q == IDX_W'(MSG_LEN - 1));
  assign full_pre = (plen_q == IDX_W'(MSG_LEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_ENC;
      idx_q     <= '0;
      plen_q    <= '0;
      taps_q    <= '0;
      seed_q    <= '0;
      cfg_err_q <= 1'b0;
      pre_err_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      plen_q    <= plen_d;
      taps_q    <= taps_d;
      seed_q    <= seed_d;
      cfg_err_q <= cfg_err_d;
      pre_err_q <= pre_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    plen_d      = plen_q;
    taps_d      = taps_q;
    seed_d      = seed_q;
    cfg_err_d   = cfg_err_q;
    pre_err_d   = pre_err_q;
    lfsr_load   = 1'b0;
    lfsr_en     = 1'b0;
    lfsr_seed   = seed_q;
    mem.raddr   = '0;
    mem.waddr   = '0;
    mem.wr_en   = 1'b0;
    mem.wr_data = '0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_CFG_PRE;
          mode_d    = mode_i;
          cfg_err_d = 1'b0;
          pre_err_d = '0;
        end
      end
      ST_CFG_PRE: begin
        mem.raddr = A_PRE;
        if (32'(mem.rd_data) > 32'(MSG_LEN)) begin
          plen_d    = IDX_W'(MSG_LEN);
          cfg_err_d = 1'b1;
        end else begin
          plen_d = IDX_W'(mem.rd_data);
        end
        state_d = ST_CFG_TAPS;
      end
      ST_CFG_TAPS: begin
        mem.raddr = A_TAPS;
        taps_d    = mem.rd_data[LFSR_W-1:0];
        state_d   = ST_CFG_START;
      end
      ST_CFG_START: begin
        mem.raddr = A_START;
        seed_d    = mem.rd_data[LFSR_W-1:0];
        state_d   = ST_LOAD;
      end
      ST_LOAD: begin
        lfsr_load = 1'b1;
        idx_d     = '0;
        if (seed_q == '0) begin
          lfsr_seed = LFSR_W'(1);
          cfg_err_d = 1'b1;
        end
        state_d = (plen_q == '0) ? ST_BODY : ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        lfsr_en = 1'b1;
        idx_d   = idx_q + IDX_W'(1);
        if (mode_q == MODE_ENC) begin
          mem.wr_en   = 1'b1;
          mem.waddr   = dst_i;
          mem.wr_data = PAD ^ ks;
        end else begin
          mem.raddr = src_i;
          if (((mem.rd_data ^ ks) != PAD) && (pre_err_q != '1))
            pre_err_d = pre_err_q + ADDR_W'(1);
        end
        if (last_pre) state_d = full_pre ? ST_DONE : ST_BODY;
      end
      ST_BODY: begin
        lfsr_en     = 1'b1;
        idx_d       = idx_q + IDX_W'(1);
        mem.wr_en   = 1'b1;
        mem.wr_data = mem.rd_data ^ ks;
        if (mode_q == MODE_ENC) begin
          mem.raddr = src_rel;
          mem.waddr = dst_i;
        end else begin
          mem.raddr = src_i;
          mem.waddr = dst_rel;
        end
        if (last_msg) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = (state_q == ST_DONE);
  assign cfg_err_o     = cfg_err_q;
  assign pre_err_cnt_o = pre_err_q;

endmodule

// File: tb/tb_lfsr_crypt_engine.sv
// Directed bench: encrypt/decrypt round trip, preamble error, bad config, async reset, back-to-back jobs.
module tb_lfsr_crypt_engine;
  import lfsr_crypt_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_e = 1'b0, mode_e = 1'b0, busy_e, done_e, cfg_err_e;
  logic       start_d = 1'b0, mode_d = 1'b0, busy_d, done_d, cfg_err_d;
  logic [7:0] perr_e, perr_d;

  lfsr_crypt_engine_if #(.DATA_W(8), .ADDR_W(8)) bus_e ();
  lfsr_crypt_engine_if #(.DATA_W(8), .ADDR_W(8)) bus_d ();

  logic [7:0] mem  [256];
  logic [7:0] orig [64];
  logic       tb_we = 1'b0;
  logic [7:0] tb_wa = '0, tb_wd = '0;

  always @(posedge clk) begin
    if (tb_we)       mem[tb_wa]       <= tb_wd;
    if (bus_e.wr_en) mem[bus_e.waddr] <= bus_e.wr_data;
    if (bus_d.wr_en) mem[bus_d.waddr] <= bus_d.wr_data;
  end
  assign bus_e.rd_data = mem[bus_e.raddr];
  assign bus_d.rd_data = mem[bus_d.raddr];

  lfsr_crypt_engine #(.SRC_BASE(0), .DST_BASE(64)) u_enc (
    .clk(clk), .rst_n(rst_n), .start_i(start_e), .mode_i(mode_e),
    .busy_o(busy_e), .done_o(done_e), .pre_err_cnt_o(perr_e), .cfg_err_o(cfg_err_e),
    .mem(bus_e)
  );

  lfsr_crypt_engine #(.SRC_BASE(64), .DST_BASE(128)) u_dec (
    .clk(clk), .rst_n(rst_n), .start_i(start_d), .mode_i(mode_d),
    .busy_o(busy_d), .done_o(done_d), .pre_err_cnt_o(perr_d), .cfg_err_o(cfg_err_d),
    .mem(bus_d)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] ks_at(input int n, input logic [5:0] seed, input logic [5:0] taps);
    logic [5:0] s;
    s = seed;
    for (int k = 0; k < n; k++) s = {s[4:0], ^(s & taps)};
    return s;
  endfunction

  task automatic mem_wr(input int a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1;
    tb_wa = 8'(a);
    tb_wd = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  // Latency counts from the cycle after the accepting edge (that cycle is 1).
  task automatic run_job(input bit dec, input logic m, output int lat, output int wr);
    @(negedge clk);
    if (dec) begin start_d = 1'b1; mode_d = m; end
    else     begin start_e = 1'b1; mode_e = m; end
    lat = -1;
    wr  = 0;
    @(posedge clk);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start_e = 1'b0;
      start_d = 1'b0;
      if (dec ? bus_d.wr_en : bus_e.wr_en) wr++;
      if (dec ? done_d : done_e) begin
        lat = c;
        break;
      end
      @(posedge clk);
    end
  endtask

  int lat, wr, errs, cnt, d1, d2, wr1, wr2, ndone;
  logic [7:0] ks63;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs_e", {busy_e, done_e, bus_e.wr_en, cfg_err_e, bus_e.raddr, bus_e.waddr, bus_e.wr_data}, 32'h0);
    check("rst_perr_d", perr_d, 8'h00);
    rst_n = 1'b1;

    for (int a = 0; a < 256; a++) begin
      logic [7:0] v;
      v = (a < 61) ? 8'((a * 37 + 11) & 255) : 8'h00;
      if (a < 64) orig[a] = v;
      mem_wr(a, v);
    end
    mem_wr(61, 8'd7);
    mem_wr(62, 8'h21);
    mem_wr(63, 8'h01);
    ks63 = {2'b00, ks_at(63, 6'h01, 6'h21)};

    // 1: encrypt
    run_job(1'b0, MODE_ENC, lat, wr);
    @(negedge clk);
    check("t1_latency", lat, 69);
    check("t1_writes", wr, 64);
    check("t1_mem64", mem[64], 8'h5E);
    check("t1_mem65", mem[65], 8'h5C);
    check("t1_mem66", mem[66], 8'h58);
    check("t1_mem71", mem[71], orig[0] ^ 8'h3D);
    check("t1_mem127", mem[127], orig[56] ^ ks63);
    check("t1_cfg_err", cfg_err_e, 1'b0);

    // 2: decrypt round trip
    run_job(1'b1, MODE_DEC, lat, wr);
    @(negedge clk);
    check("t2_latency", lat, 69);
    check("t2_writes", wr, 57);
    check("t2_perr", perr_d, 8'd0);
    check("t2_cfg_err", cfg_err_d, 1'b0);
    check("t2_mem128", mem[128], orig[0]);
    errs = 0;
    for (int k = 0; k < 57; k++) if (mem[128 + k] !== orig[k]) errs++;
    check("t2_body_errs", errs, 0);

    // 3: corrupted preamble word
    for (int k = 0; k < 57; k++) mem_wr(128 + k, 8'h00);
    mem_wr(66, 8'h00);
    run_job(1'b1, MODE_DEC, lat, wr);
    @(negedge clk);
    check("t3_perr", perr_d, 8'd1);
    errs = 0;
    for (int k = 0; k < 57; k++) if (mem[128 + k] !== orig[k]) errs++;
    check("t3_body_errs", errs, 0);

    // 4: zero seed and oversize preamble
    mem_wr(61, 8'd200);
    mem_wr(63, 8'h00);
    run_job(1'b0, MODE_ENC, lat, wr);
    @(negedge clk);
    check("t4_latency", lat, 69);
    check("t4_writes", wr, 64);
    check("t4_cfg_err", cfg_err_e, 1'b1);
    check("t4_mem64", mem[64], 8'h5E);
    check("t4_mem127", mem[127], 8'h5F ^ ks63);
    mem_wr(61, 8'd7);
    mem_wr(63, 8'h01);

    // 5: asynchronous reset mid-body
    @(negedge clk);
    start_e = 1'b1;
    mode_e  = MODE_ENC;
    @(posedge clk);
    for (int c = 1; c < 30; c++) begin
      @(negedge clk);
      start_e = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    check("t5_pre_wr_en", bus_e.wr_en, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_async_outs", {busy_e, done_e, bus_e.wr_en, cfg_err_e, bus_e.raddr, bus_e.waddr, bus_e.wr_data}, 32'h0);
    check("t5_async_perr_d", perr_d, 8'd0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus_e.wr_en) cnt++;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus_e.wr_en || busy_e) cnt++;
    end
    check("t5_no_activity", cnt, 0);
    mem_wr(64, 8'h00);
    run_job(1'b0, MODE_ENC, lat, wr);
    @(negedge clk);
    check("t5_latency", lat, 69);
    check("t5_mem64", mem[64], 8'h5E);

    // 6: start held high, mode wiggled while busy
    for (int k = 64; k < 72; k++) mem_wr(k, 8'h00);
    @(negedge clk);
    start_e = 1'b1;
    mode_e  = MODE_ENC;
    @(posedge clk);
    ndone = 0; d1 = -1; d2 = -1; wr1 = 0; wr2 = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      mode_e = ((c >= 20 && c < 25) || (c >= 90 && c < 95)) ? MODE_DEC : MODE_ENC;
      if (bus_e.wr_en) begin
        if (ndone == 0) wr1++;
        else wr2++;
      end
      if (done_e) begin
        ndone++;
        if (ndone == 1) d1 = c;
        else begin
          d2 = c;
          start_e = 1'b0;
          break;
        end
      end
      @(posedge clk);
    end
    repeat (3) @(negedge clk);
    check("t6_first_done", d1, 69);
    check("t6_done_period", d2 - d1, 70);
    check("t6_writes_job1", wr1, 64);
    check("t6_writes_job2", wr2, 64);
    check("t6_mem71", mem[71], orig[0] ^ 8'h3D);
    check("t6_idle_after", busy_e, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
